// File: rtl/csa_resolve_pkg.sv
// Shared sizing helpers and segment type for the carry-save resolve pipeline.
package csa_resolve_pkg;

  localparam int SEG_W_DFLT = 16;

  typedef logic [SEG_W_DFLT-1:0] seg_t;

  // Two extra bits: one for the C<<1 weighting, one for the final carry.
  function automatic int out_w(input int bitlen);
    return bitlen + 2;
  endfunction

  function automatic int num_seg(input int bitlen, input int seg_w);
    return (out_w(bitlen) + seg_w - 1) / seg_w;
  endfunction

endpackage

// File: rtl/csa_resolve_seg.sv
// One pipeline stage: W-bit add with carry-in, registered sum/carry/valid, 1 clk.
// Holds everything while en is low (global stall).
module csa_resolve_seg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         vld_in,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         vld,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (en) begin
      vld  <= vld_in;
      sum  <= total[W-1:0];
      cout <= total[W];
    end
  end

endmodule

// File: rtl/csa_resolve_pipe.sv
// Resolves carry-save (C,S) into S + (C<<1), one segment per stage, NUM_SEG clk latency.
// Global stall on out_valid && !out_ready; optional tag chain under CSA_RESOLVE_TAG_EN.
module csa_resolve_pipe
  import csa_resolve_pkg::*;
#(
  parameter int BITLEN = 34,
  parameter int SEG_W  = 16,
  parameter int TAG_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BITLEN-1:0]        in_c,
  input  logic [BITLEN-1:0]        in_s,
`ifdef CSA_RESOLVE_TAG_EN
  input  logic [TAG_W-1:0]         in_tag,
  output logic [TAG_W-1:0]         out_tag,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [out_w(BITLEN)-1:0] out_sum
);

  localparam int OUT_W   = out_w(BITLEN);
  localparam int NUM_SEG = num_seg(BITLEN, SEG_W);

  logic [1:0]       rst_q;
  logic             sync_n;
  logic             adv;
  logic [OUT_W-1:0] a_ext;
  logic [OUT_W-1:0] b_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= 2'b00;
    else        rst_q <= {rst_q[0], 1'b1};
  end
  assign sync_n = rst_q[1];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign a_ext = {2'b00, in_s};
  assign b_ext = {1'b0, in_c, 1'b0};

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stg
    localparam int LO = k * SEG_W;
    localparam int HI = (LO + SEG_W > OUT_W) ? OUT_W : LO + SEG_W;
    localparam int W  = HI - LO;

    // a_up/b_up: operand bits from LO upward, still unadded at this stage
    logic [OUT_W-LO-1:0] a_up;
    logic [OUT_W-LO-1:0] b_up;
    logic                cin;
    logic                vin;
    logic                vld;
    logic [W-1:0]        sum;
    logic                co;
    logic [HI-1:0]       res;

    if (k == 0) begin : g_first
      assign a_up = a_ext;
      assign b_up = b_ext;
      assign cin  = 1'b0;
      assign vin  = in_valid & in_ready;
      assign res  = sum;
    end else begin : g_next
      logic [LO-1:0] dsk;

      assign a_up = g_stg[k-1].g_skew.a_skw;
      assign b_up = g_stg[k-1].g_skew.b_skw;
      assign cin  = g_stg[k-1].co;
      assign vin  = g_stg[k-1].vld;

      always_ff @(posedge clk or negedge sync_n) begin
        if (!sync_n)  dsk <= '0;
        else if (adv) dsk <= g_stg[k-1].res;
      end
      assign res = {sum, dsk};
    end

    csa_resolve_seg #(.W(W)) u_seg (
      .clk    (clk),
      .rst_n  (sync_n),
      .en     (adv),
      .vld_in (vin),
      .a      (a_up[W-1:0]),
      .b      (b_up[W-1:0]),
      .cin    (cin),
      .vld    (vld),
      .sum    (sum),
      .cout   (co)
    );

    if (k < NUM_SEG - 1) begin : g_skew
      logic [OUT_W-HI-1:0] a_skw;
      logic [OUT_W-HI-1:0] b_skw;

      always_ff @(posedge clk or negedge sync_n) begin
        if (!sync_n) begin
          a_skw <= '0;
          b_skw <= '0;
        end else if (adv) begin
          a_skw <= a_up[OUT_W-LO-1:W];
          b_skw <= b_up[OUT_W-LO-1:W];
        end
      end
    end else begin : g_top
      // Top segment cannot carry out: OUT_W already covers the full sum range.
      logic co_unused;
      assign co_unused = co;
    end
  end

  assign out_valid = g_stg[NUM_SEG-1].vld;
  assign out_sum   = g_stg[NUM_SEG-1].res;

`ifdef CSA_RESOLVE_TAG_EN
  logic [TAG_W-1:0] tag_q [NUM_SEG];

  always_ff @(posedge clk or negedge sync_n) begin
    if (!sync_n) begin
      for (int i = 0; i < NUM_SEG; i++) tag_q[i] <= '0;
    end else if (adv) begin
      tag_q[0] <= in_tag;
      for (int i = 1; i < NUM_SEG; i++) tag_q[i] <= tag_q[i-1];
    end
  end
  assign out_tag = tag_q[NUM_SEG-1];
`else
  localparam int TAG_W_UNUSED = TAG_W;
`endif

endmodule

// File: tb/tb_csa_resolve_pipe.sv
// Directed bench for csa_resolve_pipe at BITLEN=34, SEG_W=16 (3-stage pipe).
module tb_csa_resolve_pipe;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [33:0] in_c      = '0;
  logic [33:0] in_s      = '0;
  logic        in_ready;
  logic        out_valid;
  logic [35:0] out_sum;
`ifdef CSA_RESOLVE_TAG_EN
  logic [7:0]  in_tag = '0;
  logic [7:0]  out_tag;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csa_resolve_pipe #(.BITLEN(34), .SEG_W(16), .TAG_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_c      (in_c),
    .in_s      (in_s),
`ifdef CSA_RESOLVE_TAG_EN
    .in_tag    (in_tag),
    .out_tag   (out_tag),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] model(input logic [33:0] c, input logic [33:0] s);
    return {2'b00, s} + {1'b0, c, 1'b0};
  endfunction

  task automatic directed(input string tag, input logic [33:0] c, input logic [33:0] s,
                          input logic [35:0] exp);
    in_c      = c;
    in_s      = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, " lat1"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, " lat2"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, " lat3 valid"}, 64'(out_valid), 64'd1);
    chk({tag, " sum"}, 64'(out_sum), 64'(exp));
    tick();
    chk({tag, " retired"}, 64'(out_valid), 64'd0);
  endtask

  logic [35:0] exp_q [$];
  logic [7:0]  tag_q [$];
  logic [35:0] held_sum;
  logic [35:0] exp_sum;
  logic        hold;
  logic        acc;
  logic        ret;
  int          sent;
  int          got;

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_sum", 64'(out_sum), 64'd0);
`ifdef CSA_RESOLVE_TAG_EN
    chk("rst out_tag", 64'(out_tag), 64'd0);
`endif
    rst_n = 1'b1;
    tick();
    tick();
    tick();

    directed("basic", 34'h0_0000_0000, 34'h3_FFFF_FFFF, 36'h3_FFFF_FFFF);
    directed("max", 34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 36'hB_FFFF_FFFD);
    directed("ripple", 34'h0_0000_8000, 34'h3_FFFF_0000, 36'h4_0000_0000);

    // Output stall holds data and deasserts in_ready
    in_c      = 34'h1_2345_6789;
    in_s      = 34'h0_0000_0001;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("stall valid", 64'(out_valid), 64'd1);
      chk("stall sum", 64'(out_sum), 64'h2_468A_CF13);
      chk("stall in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("unstall in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("unstall retired", 64'(out_valid), 64'd0);

    // Back-to-back random pairs with random output stalls
    sent     = 0;
    got      = 0;
    hold     = 1'b0;
    held_sum = '0;
    in_c     = {2'($urandom_range(0, 3)), 32'($urandom())};
    in_s     = {2'($urandom_range(0, 3)), 32'($urandom())};
`ifdef CSA_RESOLVE_TAG_EN
    in_tag   = 8'd1;
`endif
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 600 && got < 20; cyc++) begin
      if (hold) begin
        chk("rnd stall valid", 64'(out_valid), 64'd1);
        chk("rnd stall sum", 64'(out_sum), 64'(held_sum));
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      if (acc) begin
        exp_q.push_back(model(in_c, in_s));
`ifdef CSA_RESOLVE_TAG_EN
        tag_q.push_back(in_tag);
`endif
      end
      if (ret) begin
        if (exp_q.size() == 0) begin
          chk("rnd spurious", 64'(exp_q.size()), 64'd1);
        end else begin
          exp_sum = exp_q.pop_front();
          chk("rnd sum", 64'(out_sum), 64'(exp_sum));
`ifdef CSA_RESOLVE_TAG_EN
          chk("rnd tag", 64'(out_tag), 64'(tag_q.pop_front()));
`endif
        end
        got++;
      end
      hold     = out_valid && !out_ready;
      held_sum = out_sum;
      tick();
      if (acc) begin
        sent++;
        if (sent < 20) begin
          in_c = {2'($urandom_range(0, 3)), 32'($urandom())};
          in_s = {2'($urandom_range(0, 3)), 32'($urandom())};
`ifdef CSA_RESOLVE_TAG_EN
          in_tag = 8'(sent + 1);
`endif
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    chk("rnd count", 64'(got), 64'd20);
    chk("rnd drained", 64'(exp_q.size()), 64'd0);

    // Reset while two results are in flight
    out_ready = 1'b0;
    in_c      = 34'h0_0000_0001;
    in_s      = 34'h0_0000_0001;
    in_valid  = 1'b1;
    tick();
    in_c = 34'h0_0000_0002;
    in_s = 34'h0_0000_0002;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre-rst valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst async valid", 64'(out_valid), 64'd0);
    chk("rst async sum", 64'(out_sum), 64'd0);
    chk("rst async in_ready", 64'(in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("post-rst no stale", 64'(out_valid), 64'd0);
      tick();
    end
    directed("post-rst", 34'h0_0000_0005, 34'h0_0000_0007, 36'h0_0000_0011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
